// File: rtl/pmips_control_if.sv
// pmips_control_if -- ID-stage control bus of the pMIPS pipeline.
//
// Carries the opcode field from the IF/ID register into the control unit.
// It also carries the decoded controls and the PC stall request back out.
//   opcode    : 4-bit opcode from IF/ID
//   PCControl : PC source request (00 PC+2/hold, 01 branch, 10 jump)
//   RegWrite, RegDst, ALUSrc, Branch, Jump, MemWrite, MemRead, MemtoReg :
//               single-bit ID-stage controls latched by ID/EX
//   ALUOp     : ALU select (000 add, 001 sub, 010 and, 011 or, 100 slt)
//   Stall     : holds the PC when 1
// Modports: master = pipeline side (drives opcode), slave = control unit.
interface pmips_control_if;
  logic [3:0] opcode;
  logic [1:0] PCControl;
  logic       RegWrite;
  logic       RegDst;
  logic       ALUSrc;
  logic       Branch;
  logic       Jump;
  logic       MemWrite;
  logic       MemRead;
  logic       MemtoReg;
  logic [2:0] ALUOp;
  logic       Stall;

  modport master (
    output opcode,
    input  PCControl, RegWrite, RegDst, ALUSrc, Branch, Jump,
    input  MemWrite, MemRead, MemtoReg, ALUOp, Stall
  );

  modport slave (
    input  opcode,
    output PCControl, RegWrite, RegDst, ALUSrc, Branch, Jump,
    output MemWrite, MemRead, MemtoReg, ALUOp, Stall
  );
endinterface

// File: rtl/pmips_control.sv
// pmips_control -- ID-stage decoder and hazard stall sequencer for pMIPS.
//
// Ports:
//   clock : pipeline clock, rising edge
//   reset : synchronous, active-high reset
//   bus   : pmips_control_if.slave (opcode in, decoded controls and Stall out)
//
// Operation: in RUN the opcode is decoded combinationally. A hazard opcode
// (0-6, 8) raises Stall in the same cycle and starts a three-cycle bubble
// sequence (STALL state). During the bubbles all controls are forced to 0
// and Stall is held high. No opcode is buffered. After the bubbles, the
// instruction then sitting in IF/ID is decoded.
//
// Optional feature: define PMIPS_CONTROL_JUMP_EN to decode opcode 9 as a
// jump. The jump sets Jump=1 and PCControl=10 and is followed by one bubble.
// Without the macro, opcode 9 is a NOP.
module pmips_control (
  input logic              clock,
  input logic              reset,
  pmips_control_if.slave   bus
);

  typedef enum logic {RUN, STALL} state_t;

  state_t     state_reg, state_next;
  logic [1:0] count_reg, count_next;

  // Raw decode of the opcode, before bubble/reset gating.
  logic [1:0] dec_pc;
  logic       dec_reg_write, dec_reg_dst, dec_alu_src, dec_branch;
  logic       dec_jump, dec_mem_write, dec_mem_read, dec_mem_to_reg;
  logic [2:0] dec_alu_op;
  logic       hazard_op;
  logic       jump_op;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= RUN;
      count_reg <= 2'd0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
    end
  end

  always_comb begin
    dec_pc         = 2'b00;
    dec_reg_write  = 1'b0;
    dec_reg_dst    = 1'b0;
    dec_alu_src    = 1'b0;
    dec_branch     = 1'b0;
    dec_jump       = 1'b0;
    dec_mem_write  = 1'b0;
    dec_mem_read   = 1'b0;
    dec_mem_to_reg = 1'b0;
    dec_alu_op     = 3'b000;
    jump_op        = 1'b0;
    case (bus.opcode)
      4'd0, 4'd1, 4'd2, 4'd3, 4'd4: begin
        dec_reg_write  = 1'b1;
        dec_reg_dst    = 1'b1;
        dec_mem_to_reg = 1'b1;
        dec_alu_op     = bus.opcode[2:0];
      end
      4'd5: begin
        dec_reg_write  = 1'b1;
        dec_alu_src    = 1'b1;
        dec_mem_to_reg = 1'b1;
      end
      4'd6: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_mem_read  = 1'b1;
      end
      4'd7: begin
        dec_alu_src   = 1'b1;
        dec_mem_write = 1'b1;
      end
      4'd8: begin
        dec_branch = 1'b1;
        dec_alu_op = 3'b001;
        dec_pc     = 2'b01;
      end
`ifdef PMIPS_CONTROL_JUMP_EN
      4'd9: begin
        dec_jump = 1'b1;
        dec_pc   = 2'b10;
        jump_op  = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Opcodes 0-6 and 8 need three bubbles. Opcode 7 (sw) and the NOPs need none.
  assign hazard_op = (bus.opcode <= 4'd6) || (bus.opcode == 4'd8);

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    case (state_reg)
      RUN: begin
        if (hazard_op) begin
          state_next = STALL;
          count_next = 2'd3;
        end else if (jump_op) begin
          state_next = STALL;
          count_next = 2'd1;
        end
      end
      STALL: begin
        // Leave on the edge where the counter reaches 0. Clamp at 0, never wrap.
        if (count_reg <= 2'd1) begin
          count_next = 2'd0;
          state_next = RUN;
        end else begin
          count_next = count_reg - 2'd1;
        end
      end
      default: begin
        state_next = RUN;
        count_next = 2'd0;
      end
    endcase
  end

  // Output gating: reset forces all outputs to 0, and STALL forces a bubble.
  always_comb begin
    bus.PCControl = 2'b00;
    bus.RegWrite  = 1'b0;
    bus.RegDst    = 1'b0;
    bus.ALUSrc    = 1'b0;
    bus.Branch    = 1'b0;
    bus.Jump      = 1'b0;
    bus.MemWrite  = 1'b0;
    bus.MemRead   = 1'b0;
    bus.MemtoReg  = 1'b0;
    bus.ALUOp     = 3'b000;
    bus.Stall     = 1'b0;
    if (!reset) begin
      if (state_reg == STALL) begin
        bus.Stall = 1'b1;
      end else begin
        bus.PCControl = dec_pc;
        bus.RegWrite  = dec_reg_write;
        bus.RegDst    = dec_reg_dst;
        bus.ALUSrc    = dec_alu_src;
        bus.Branch    = dec_branch;
        bus.Jump      = dec_jump;
        bus.MemWrite  = dec_mem_write;
        bus.MemRead   = dec_mem_read;
        bus.MemtoReg  = dec_mem_to_reg;
        bus.ALUOp     = dec_alu_op;
        bus.Stall     = hazard_op | jump_op;
      end
    end
  end

endmodule

// File: tb/tb_pmips_control.sv
// tb_pmips_control -- directed self-checking bench for pmips_control.
// The outputs are packed into one 14-bit word for comparison, in this order:
// {PCControl[1:0], RegWrite, RegDst, ALUSrc, Branch, Jump, MemWrite,
//  MemRead, MemtoReg, ALUOp[2:0], Stall}
module tb_pmips_control;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pmips_control_if bus ();

  pmips_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  localparam logic [13:0] EXP_ZERO   = 14'b00_00000000_000_0;
  localparam logic [13:0] EXP_BUBBLE = 14'b00_00000000_000_1;
  localparam logic [13:0] EXP_ADD    = 14'b00_11000001_000_1;
  localparam logic [13:0] EXP_SUB    = 14'b00_11000001_001_1;
  localparam logic [13:0] EXP_AND    = 14'b00_11000001_010_1;
  localparam logic [13:0] EXP_OR     = 14'b00_11000001_011_1;
  localparam logic [13:0] EXP_SLT    = 14'b00_11000001_100_1;
  localparam logic [13:0] EXP_ADDI   = 14'b00_10100001_000_1;
  localparam logic [13:0] EXP_LW     = 14'b00_10100010_000_1;
  localparam logic [13:0] EXP_SW     = 14'b00_00100100_000_0;
  localparam logic [13:0] EXP_BEQ    = 14'b01_00010000_001_1;
  localparam logic [13:0] EXP_JUMP   = 14'b10_00001000_000_1;

  function automatic logic [13:0] observed();
    return {bus.PCControl, bus.RegWrite, bus.RegDst, bus.ALUSrc, bus.Branch,
            bus.Jump, bus.MemWrite, bus.MemRead, bus.MemtoReg, bus.ALUOp,
            bus.Stall};
  endfunction

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reset for one edge, then release it with the given opcode in IF/ID.
  task automatic do_reset(input logic [3:0] op);
    reset = 1'b1;
    bus.opcode = 4'd0;
    step();
    reset = 1'b0;
    bus.opcode = op;
  endtask

  task automatic test_reset();
    logic [13:0] obs;
    reset = 1'b1;
    bus.opcode = 4'd0;
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clock);
      obs = observed();
      checks++;
      if (obs !== EXP_ZERO) begin
        errors++;
        $display("FAIL reset_hold cyc%0d: got %b want %b", i, obs, EXP_ZERO);
      end
    end
    step();
    reset = 1'b0;
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_ADD) begin
      errors++;
      $display("FAIL reset_first_decode: got %b want %b", obs, EXP_ADD);
    end
    $display("test_reset: first post-reset add decode %b", obs);
  endtask

  task automatic test_add_sw();
    logic [13:0] obs;
    do_reset(4'd0);
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_ADD) begin
      errors++;
      $display("FAIL add_decode: got %b want %b", obs, EXP_ADD);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      bus.opcode = 4'd7;
      @(negedge clock);
      obs = observed();
      checks++;
      if (obs !== EXP_BUBBLE) begin
        errors++;
        $display("FAIL add_bubble%0d: got %b want %b", i, obs, EXP_BUBBLE);
      end
    end
    for (int i = 0; i < 2; i++) begin
      step();
      @(negedge clock);
      obs = observed();
      checks++;
      if (obs !== EXP_SW) begin
        errors++;
        $display("FAIL add_then_sw%0d: got %b want %b", i, obs, EXP_SW);
      end
    end
    $display("test_add_sw: add, 3 bubbles, sw %b", obs);
  endtask

  task automatic test_beq();
    logic [13:0] obs;
    do_reset(4'd8);
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_BEQ) begin
      errors++;
      $display("FAIL beq_decode: got %b want %b", obs, EXP_BEQ);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      bus.opcode = 4'd0;  // hazard opcode during bubbles must not reload
      @(negedge clock);
      obs = observed();
      checks++;
      if (obs !== EXP_BUBBLE) begin
        errors++;
        $display("FAIL beq_bubble%0d: got %b want %b", i, obs, EXP_BUBBLE);
      end
    end
    step();
    bus.opcode = 4'd7;
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_SW) begin
      errors++;
      $display("FAIL beq_no_reload: got %b want %b", obs, EXP_SW);
    end
    $display("test_beq: beq, 3 bubbles, sw %b", obs);
  endtask

  task automatic test_lw();
    logic [13:0] obs;
    do_reset(4'd6);
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_LW) begin
      errors++;
      $display("FAIL lw_decode: got %b want %b", obs, EXP_LW);
    end
    for (int i = 1; i <= 3; i++) begin
      step();
      bus.opcode = 4'd10;
      @(negedge clock);
      obs = observed();
      checks++;
      if (obs !== EXP_BUBBLE) begin
        errors++;
        $display("FAIL lw_bubble%0d: got %b want %b", i, obs, EXP_BUBBLE);
      end
    end
    step();
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL lw_then_nop: got %b want %b", obs, EXP_ZERO);
    end
    $display("test_lw: lw, 3 bubbles, nop %b", obs);
  endtask

  task automatic test_reset_mid_stall();
    logic [13:0] obs;
    do_reset(4'd8);
    step();  // bubble 1
    step();  // bubble 2
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_BUBBLE) begin
      errors++;
      $display("FAIL midrst_bubble2: got %b want %b", obs, EXP_BUBBLE);
    end
    reset = 1'b1;
    bus.opcode = 4'd7;
    #1;
    obs = observed();
    checks++;
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL midrst_reset_outputs: got %b want %b", obs, EXP_ZERO);
    end
    step();
    reset = 1'b0;
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_SW) begin
      errors++;
      $display("FAIL midrst_sw_after: got %b want %b", obs, EXP_SW);
    end
    $display("test_reset_mid_stall: sw after abort %b", obs);
  endtask

  task automatic test_alu_ops();
    logic [3:0]  ops [6]  = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd7};
    logic [13:0] exps [6] = '{EXP_SUB, EXP_AND, EXP_OR, EXP_SLT, EXP_ADDI, EXP_SW};
    logic [13:0] obs;
    for (int i = 0; i < 6; i++) begin
      do_reset(ops[i]);
      @(negedge clock);
      obs = observed();
      checks++;
      if (obs !== exps[i]) begin
        errors++;
        $display("FAIL alu_op%0d: got %b want %b", ops[i], obs, exps[i]);
      end
      $display("test_alu_ops: opcode %0d -> %b", ops[i], obs);
    end
  endtask

  task automatic test_nop();
    logic [3:0]  ops [3] = '{4'd10, 4'd12, 4'd15};
    logic [13:0] obs;
    for (int i = 0; i < 3; i++) begin
      do_reset(ops[i]);
      for (int c = 0; c < 2; c++) begin
        if (c != 0) step();
        @(negedge clock);
        obs = observed();
        checks++;
        if (obs !== EXP_ZERO) begin
          errors++;
          $display("FAIL nop_op%0d_c%0d: got %b want %b", ops[i], c, obs, EXP_ZERO);
        end
      end
      $display("test_nop: opcode %0d -> %b", ops[i], obs);
    end
  endtask

  task automatic test_jump();
    logic [13:0] obs;
    do_reset(4'd9);
    @(negedge clock);
    obs = observed();
    checks++;
`ifdef PMIPS_CONTROL_JUMP_EN
    if (obs !== EXP_JUMP) begin
      errors++;
      $display("FAIL jump_decode: got %b want %b", obs, EXP_JUMP);
    end
    step();
    bus.opcode = 4'd7;
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_BUBBLE) begin
      errors++;
      $display("FAIL jump_bubble: got %b want %b", obs, EXP_BUBBLE);
    end
    step();
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_SW) begin
      errors++;
      $display("FAIL jump_then_sw: got %b want %b", obs, EXP_SW);
    end
`else
    if (obs !== EXP_ZERO) begin
      errors++;
      $display("FAIL op9_nop: got %b want %b", obs, EXP_ZERO);
    end
    step();
    bus.opcode = 4'd7;
    @(negedge clock);
    obs = observed();
    checks++;
    if (obs !== EXP_SW) begin
      errors++;
      $display("FAIL op9_then_sw: got %b want %b", obs, EXP_SW);
    end
`endif
    $display("test_jump: opcode 9 sequence ends %b", obs);
  endtask

  initial begin
    bus.opcode = 4'd0;
    test_reset();
    test_add_sw();
    test_beq();
    test_lw();
    test_reset_mid_stall();
    test_alu_ops();
    test_nop();
    test_jump();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pmips_control.md
PMIPS_CONTROL -- requirements
Module: pmips_control

Interface
REQ-001 Reset and clock: reset is synchronous and active-high; clock is clock.
REQ-002 clock  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  4  opcode field of the IF/ID instruction register.
REQ-005 PCControl  output  2  PC source request: 00 = PC+2/hold, 01 = branch, 10 = jump.
REQ-006 RegWrite, RegDst, ALUSrc, Branch, Jump, MemWrite, MemRead, MemtoReg  output  1 each  ID-stage controls, latched by the ID/EX register.
REQ-007 ALUOp  output  3  ALU select: 000 add, 001 sub, 010 and, 011 or, 100 slt.
REQ-008 Stall  output  1  holds the PC when 1.

Function
REQ-009 Decode SHALL be combinational from opcode while state = RUN, per REQ-010..REQ-015.
REQ-010 Opcodes 0-4 (add, sub, and, or, slt): RegWrite=1, RegDst=1 (rd), ALUSrc=0, MemtoReg=1 (ALU result), ALUOp = opcode[2:0].
REQ-011 Opcode 5 (addi): RegWrite=1, RegDst=0 (rt), ALUSrc=1, ALUOp=000, MemtoReg=1.
REQ-012 Opcode 6 (lw): RegWrite=1, RegDst=0, ALUSrc=1, ALUOp=000, MemRead=1, MemtoReg=0 (memory data).
REQ-013 Opcode 7 (sw): ALUSrc=1, ALUOp=000, MemWrite=1, RegWrite=0.
REQ-014 Opcode 8 (beq): Branch=1, ALUOp=001, ALUSrc=0, PCControl=01.
REQ-015 Opcodes 10-15, and opcode 9 when the jump feature is absent, are NOP: all control outputs 0.
REQ-016 A hazard opcode is 0-6 or 8. In RUN, a hazard opcode SHALL assert Stall=1 in the same cycle and load the stall counter with 3.
REQ-017 A non-hazard opcode (7, NOP) SHALL leave Stall=0 and the state at RUN.
REQ-018 In STALL, all decode outputs SHALL be 0 (bubble) and Stall SHALL be 1; the counter decrements each cycle.
REQ-019 The transition STALL->RUN occurs on the edge where the counter reaches 0, so exactly 3 bubble cycles follow the hazard instruction.
REQ-020 The instruction decoded on the first RUN cycle after a stall is the instruction currently in IF/ID; no opcode is buffered internally.
REQ-021 Stall SHALL never be asserted by opcode while in STALL, and a new hazard SHALL not reload the counter.
REQ-022 The counter is 2 bits and SHALL not wrap: it saturates at 0 and is only loaded from RUN.

Reset
REQ-023 With reset=1 at a rising edge, state SHALL become RUN and the counter 0.
REQ-024 While reset=1, all outputs SHALL be 0, including Stall and PCControl.
REQ-025 Reset asserted mid-stall SHALL abort the stall; the first cycle after reset deasserts SHALL decode opcode normally.

Configuration
REQ-026 Macro PMIPS_CONTROL_JUMP_EN defined: opcode 9 decodes as Jump=1 and PCControl=10, asserts Stall=1 for that cycle, and enters STALL with the counter loaded with 1 (one bubble).
REQ-027 Macro PMIPS_CONTROL_JUMP_EN undefined: opcode 9 is a NOP, Jump is tied to 0, and PCControl never equals 10.

Verification
REQ-028 Reset high 2 cycles with opcode=0, then low: outputs all 0 during reset; the first post-reset cycle gives RegWrite=1, RegDst=1, ALUOp=000, Stall=1.
REQ-029 add in RUN, then IF/ID held at sw: Stall=1 for 4 cycles (decode cycle plus 3 bubbles with all controls 0); the 5th cycle decodes sw with MemWrite=1 and Stall=0.
REQ-030 beq: Branch=1, PCControl=01, ALUOp=001 for one cycle, followed by 3 bubble cycles; opcode changes to 0 during the bubbles cause no output change and no counter reload.
REQ-031 lw: MemRead=1, MemtoReg=0, ALUSrc=1, RegDst=0, followed by 3 bubbles.
REQ-032 Reset pulsed on bubble 2 of a beq stall, with opcode=7: the next cycle decodes sw with Stall=0.
REQ-033 opcode=9, built with and without PCControl JUMP_EN: with the macro, Jump=1, PCControl=10, then 1 bubble; without it, all outputs 0 and Stall=0.
